// File: rtl/arb_pkg.sv
// Shared types for the round-robin lock arbiter.
// Holds the arbiter FSM state encoding so checkers can decode it by name.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: lowest set req index at or after ptr, wrapping.
// The upper copy of req is unmasked, so a miss above ptr falls through to the wrapped winner.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 any,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);
   localparam int PW = IW + 1;

   logic [N-1:0]   hi_mask;
   logic [2*N-1:0] dbl;
   logic [PW-1:0]  pos;

   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = (i >= int'(ptr));
      end
      dbl = {req, req & hi_mask};
      pos = '0;
      // Scan downward so the last hit is the lowest set bit.
      for (int i = 2 * N - 1; i >= 0; i--) begin
         if (dbl[i]) begin
            pos = PW'(i);
         end
      end
      any = |req;
      // N is a power of two, so dropping the top bit is the mod-N wrap.
      idx = pos[IW-1:0];
   end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks a grant until done, request drop or MAX_HOLD expiry.
// Every grant is followed by at least one idle cycle before the next one.
module rr_lock_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         done,
   output logic [N-1:0]         gnt,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 timeout,
   output logic [$clog2(N)-1:0] ptr
);

   // Handshake: req is a level held for as long as the requester wants the resource;
   // gnt is registered and appears one cycle after an idle-state pick; the owner
   // keeps it until it pulses done[gnt_id] or drops req[gnt_id]; done and req
   // changes on any other bit are ignored while the grant is held.

   localparam int IW          = $clog2(N);
   localparam int HCW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_LAST_I);

   arb_state_e     state;
   logic [HCW-1:0] hold_cnt;

   logic           pick_any;
   logic [IW-1:0]  pick_idx;

   logic           rel_done;
   logic           rel_drop;
   logic           rel_max;
   logic           release_now;

   rr_pick #(
      .N(N)
   ) u_pick (
      .req(req),
      .ptr(ptr),
      .any(pick_any),
      .idx(pick_idx)
   );

   always_comb begin
      rel_done    = done[gnt_id];
      rel_drop    = !req[gnt_id];
      rel_max     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      release_now = rel_done || rel_drop || rel_max;
   end

   assign gnt_valid = |gnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ARB_IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (en && pick_any) begin
                  state    <= ARB_BUSY;
                  gnt      <= N'(1) << pick_idx;
                  gnt_id   <= pick_idx;
                  ptr      <= pick_idx + IW'(1);
                  hold_cnt <= '0;
               end
            end
            ARB_BUSY: begin
               if (release_now) begin
                  state    <= ARB_IDLE;
                  gnt      <= '0;
                  gnt_id   <= '0;
                  hold_cnt <= '0;
                  // Only a pure expiry counts as a forced release.
                  timeout  <= rel_max && !rel_done && !rel_drop;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + HCW'(1);
               end
            end
            default: begin
               state <= ARB_IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (N=4, MAX_HOLD=8) with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_lock_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       timeout;
   logic [1:0] ptr;

   int vectors     = 0;
   int miscompares = 0;

   rr_lock_arbiter #(
      .N(4),
      .MAX_HOLD(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .en(en),
      .req(req),
      .done(done),
      .gnt(gnt),
      .gnt_valid(gnt_valid),
      .gnt_id(gnt_id),
      .timeout(timeout),
      .ptr(ptr)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      req  = 4'b0000;
      done = 4'b0000;
      @(posedge clock);
      #3 reset = 1'b1;
      #4 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b0;
      req   = 4'b0000;
      done  = 4'b0000;
      repeat (2) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      vectors++;
      if ({gnt_valid, gnt, gnt_id, timeout, ptr} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_state: got %b, want %b", {gnt_valid, gnt, gnt_id, timeout, ptr}, 10'b0);
      end
   endtask

   task automatic test_basic();
      en  = 1'b1;
      req = 4'b0101;
      step();
      vectors++;
      if ({gnt, gnt_id, ptr} !== {4'b0001, 2'd0, 2'd1}) begin
         miscompares++;
         $display("FAIL basic_first: gnt/id/ptr got %b/%0d/%0d, want 0001/0/1", gnt, gnt_id, ptr);
      end
      done = 4'b0001;
      step();
      vectors++;
      if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_release: gnt/timeout got %b/%b, want 0000/0", gnt, timeout);
      end
      done = 4'b0000;
      step();
      vectors++;
      if ({gnt, gnt_id, ptr} !== {4'b0100, 2'd2, 2'd3}) begin
         miscompares++;
         $display("FAIL basic_second: gnt/id/ptr got %b/%0d/%0d, want 0100/2/3", gnt, gnt_id, ptr);
      end
      req = 4'b0000;
      step();
      vectors++;
      if ({gnt_valid, gnt, timeout} !== {1'b0, 4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL basic_drop: valid/gnt/timeout got %b/%b/%b, want 0/0000/0", gnt_valid, gnt, timeout);
      end
      step();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_id;
      logic [3:0] exp_gnt;
      apply_reset();
      en  = 1'b1;
      req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         exp_id  = 2'(k % 4);
         exp_gnt = 4'(1) << exp_id;
         vectors++;
         if ({gnt_valid, gnt, gnt_id} !== {1'b1, exp_gnt, exp_id}) begin
            miscompares++;
            $display("FAIL rr_grant[%0d]: gnt/id got %b/%0d, want %b/%0d", k, gnt, gnt_id, exp_gnt, exp_id);
         end
         step();
         vectors++;
         if (gnt !== exp_gnt) begin
            miscompares++;
            $display("FAIL rr_hold[%0d]: gnt got %b, want %b", k, gnt, exp_gnt);
         end
         done = exp_gnt;
         step();
         done = 4'b0000;
         vectors++;
         if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL rr_gap[%0d]: gnt/timeout got %b/%b, want 0000/0", k, gnt, timeout);
         end
         if (k < 4) step();
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_timeout();
      req = 4'b0100;
      step();
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({gnt, timeout} !== {4'b0100, 1'b0}) begin
            miscompares++;
            $display("FAIL to_hold[%0d]: gnt/timeout got %b/%b, want 0100/0", i, gnt, timeout);
         end
         step();
      end
      vectors++;
      if ({gnt, gnt_id, timeout} !== {4'b0000, 2'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL to_pulse: gnt/id/timeout got %b/%0d/%b, want 0000/0/1", gnt, gnt_id, timeout);
      end
      step();
      vectors++;
      if ({gnt, timeout} !== {4'b0100, 1'b0}) begin
         miscompares++;
         $display("FAIL to_regrant: gnt/timeout got %b/%b, want 0100/0", gnt, timeout);
      end
      req = 4'b0000;
      step();
      vectors++;
      if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL to_drop_no_pulse: gnt/timeout got %b/%b, want 0000/0", gnt, timeout);
      end
      step();
   endtask

   task automatic test_lock();
      req = 4'b0010;
      step();
      vectors++;
      if ({gnt, gnt_id} !== {4'b0010, 2'd1}) begin
         miscompares++;
         $display("FAIL lock_grant: gnt/id got %b/%0d, want 0010/1", gnt, gnt_id);
      end
      done = 4'b1000;
      req  = 4'b0011;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL lock_hold[%0d]: gnt got %b, want 0010", i, gnt);
         end
      end
      done = 4'b0000;
      req  = 4'b0001;
      step();
      vectors++;
      if ({gnt, timeout} !== {4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL lock_release: gnt/timeout got %b/%b, want 0000/0", gnt, timeout);
      end
      step();
      vectors++;
      if ({gnt, gnt_id, ptr} !== {4'b0001, 2'd0, 2'd1}) begin
         miscompares++;
         $display("FAIL lock_next: gnt/id/ptr got %b/%0d/%0d, want 0001/0/1", gnt, gnt_id, ptr);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_enable();
      en  = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL en_blocked[%0d]: gnt got %b, want 0000", i, gnt);
         end
      end
      en = 1'b1;
      step();
      vectors++;
      if ({gnt, ptr} !== {4'b0010, 2'd2}) begin
         miscompares++;
         $display("FAIL en_grant: gnt/ptr got %b/%0d, want 0010/2", gnt, ptr);
      end
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL en_hold_busy[%0d]: gnt got %b, want 0010", i, gnt);
         end
      end
      done = 4'b0010;
      step();
      done = 4'b0000;
      vectors++;
      if (gnt !== 4'b0000) begin
         miscompares++;
         $display("FAIL en_release: gnt got %b, want 0000", gnt);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({gnt, ptr} !== {4'b0000, 2'd2}) begin
            miscompares++;
            $display("FAIL en_no_regrant[%0d]: gnt/ptr got %b/%0d, want 0000/2", i, gnt, ptr);
         end
      end
      req = 4'b0000;
      en  = 1'b1;
      step();
   endtask

   task automatic test_async_reset();
      req = 4'b1111;
      step();
      vectors++;
      if ({gnt, gnt_id, ptr} !== {4'b0100, 2'd2, 2'd3}) begin
         miscompares++;
         $display("FAIL ar_busy: gnt/id/ptr got %b/%0d/%0d, want 0100/2/3", gnt, gnt_id, ptr);
      end
      req = 4'b0110;
      #3 reset = 1'b1;
      #1;
      vectors++;
      if ({gnt_valid, gnt, gnt_id, timeout, ptr} !== 10'b0) begin
         miscompares++;
         $display("FAIL ar_immediate: got %b, want %b", {gnt_valid, gnt, gnt_id, timeout, ptr}, 10'b0);
      end
      step();
      vectors++;
      if ({gnt_valid, gnt, ptr} !== 7'b0) begin
         miscompares++;
         $display("FAIL ar_held: valid/gnt/ptr got %b/%b/%0d, want 0/0000/0", gnt_valid, gnt, ptr);
      end
      #3 reset = 1'b0;
      step();
      vectors++;
      if ({gnt, gnt_id, ptr} !== {4'b0010, 2'd1, 2'd2}) begin
         miscompares++;
         $display("FAIL ar_lowest: gnt/id/ptr got %b/%0d/%0d, want 0010/1/2", gnt, gnt_id, ptr);
      end
      req = 4'b0000;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_lock();
      test_enable();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
